// File: rtl/hevc_fir_pkg.sv
// Shared constants for the HEVC luma sub-pixel FIR: fraction codes, 8-tap coefficients, rounding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hevc_fir_pkg;

    localparam logic [1:0] FRAC_INT = 2'd0;
    localparam logic [1:0] FRAC_A   = 2'd1;
    localparam logic [1:0] FRAC_B   = 2'd2;
    localparam logic [1:0] FRAC_C   = 2'd3;

    localparam int NUM_TAPS  = 8;
    localparam int ROUND_OFS = 32;
    localparam int SHIFT     = 6;
    localparam int INT_GAIN  = 1 << SHIFT;

    typedef logic signed [7:0] coef_t;

    // Rows are A, B, C; integer position has no row of its own.
    localparam coef_t COEF_TBL [3][NUM_TAPS] = '{
        '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0},
        '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1},
        '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1}
    };

    // The integer position becomes a single centre tap of 1<<SHIFT, so the shared
    // round/shift path returns p[3] unchanged and can never saturate.
    function automatic coef_t tap_coef(input logic [1:0] frac, input logic [2:0] k);
        if (frac == FRAC_INT) begin
            return (k == 3'd3) ? coef_t'(INT_GAIN) : coef_t'(0);
        end
        return COEF_TBL[frac - 2'd1][k];
    endfunction

endpackage

// File: rtl/hevc_fir_lane.sv
// One 8-tap luma FIR lane (products, adder tree, round/clip); FIR_CLIP_FLAG_EN adds a saturation flag.
// Latency: 3 cycles (S1 products, S2 sum, S3 rounded/clipped pixel).
// Backpressure: every stage holds while en is low.
module hevc_fir_lane
    import hevc_fir_pkg::*;
#(
    parameter int PIXEL_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [1:0]                  frac,
    input  logic [NUM_TAPS*PIXEL_W-1:0] taps,
    output logic [PIXEL_W-1:0]          pix
`ifdef FIR_CLIP_FLAG_EN
    ,
    output logic                        sat
`endif
);

    localparam int ACC_W = PIXEL_W + 8;
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(ROUND_OFS);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIXEL_W) - 1);

    logic signed [ACC_W-1:0] prod_d [NUM_TAPS];
    logic signed [ACC_W-1:0] prod_q [NUM_TAPS];
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] sum_q;
    logic signed [ACC_W-1:0] rnd;
    logic [PIXEL_W-1:0]      pix_d;

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod_d[k] = $signed({8'b0, taps[k*PIXEL_W +: PIXEL_W]}) * ACC_W'(tap_coef(frac, 3'(k)));
        end
    end

    assign sum_d = ((prod_q[0] + prod_q[1]) + (prod_q[2] + prod_q[3]))
                 + ((prod_q[4] + prod_q[5]) + (prod_q[6] + prod_q[7]));

    // Arithmetic shift floors negative sums toward -inf before the clip.
    assign rnd = (sum_q + RND) >>> SHIFT;

    always_comb begin
        pix_d = rnd[PIXEL_W-1:0];
        if (rnd[ACC_W-1]) begin
            pix_d = '0;
        end else if (rnd > PIX_MAX) begin
            pix_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod_q[k] <= '0;
            end
            sum_q <= '0;
            pix   <= '0;
        end else if (en) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod_q[k] <= prod_d[k];
            end
            sum_q <= sum_d;
            pix   <= pix_d;
        end
    end

`ifdef FIR_CLIP_FLAG_EN
    logic sat_d;
    assign sat_d = rnd[ACC_W-1] || (rnd > PIX_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            sat <= 1'b0;
        end else if (en) begin
            sat <= sat_d;
        end
    end
`endif

endmodule

// File: rtl/hevc_luma_fir_pipe.sv
// HEVC luma sub-pixel interpolator, NUM_LANES outputs per row beat; FIR_CLIP_FLAG_EN adds out_clip.
// Latency: 3 cycles accept-to-out_valid, 1 beat/cycle throughput.
// Backpressure: global stall; in_ready = !out_valid || out_ready, all stages (bubbles too) hold.
module hevc_luma_fir_pipe
    import hevc_fir_pkg::*;
#(
    parameter int NUM_LANES  = 8,
    parameter int PIXEL_W    = 8,
    parameter int BLOCK_ROWS = 15
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [1:0]                       in_frac,
    input  logic [(NUM_LANES+7)*PIXEL_W-1:0] in_pixels,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_LANES*PIXEL_W-1:0]     out_pixels,
    output logic                             out_last
`ifdef FIR_CLIP_FLAG_EN
    ,
    output logic [NUM_LANES-1:0]             out_clip
`endif
);

    localparam int ROW_W = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BLOCK_ROWS - 1);

    logic             advance;
    logic             in_xfer;
    logic             row_wrap;
    logic [ROW_W-1:0] row_q;
    logic [3:1]       vld_q;
    logic [3:1]       last_q;

    assign out_valid = vld_q[3];
    assign out_last  = last_q[3];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign in_xfer   = in_valid && advance;
    assign row_wrap  = (row_q == ROW_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q  <= '0;
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            if (in_xfer) begin
                row_q <= row_wrap ? '0 : row_q + 1'b1;
            end
            if (advance) begin
                vld_q  <= {vld_q[2:1], in_valid};
                last_q <= {last_q[2:1], in_valid && row_wrap};
            end
        end
    end

    // frac is consumed when the S1 products are formed, so it needs no later copies.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        hevc_fir_lane #(
            .PIXEL_W (PIXEL_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .en    (advance),
            .frac  (in_frac),
            .taps  (in_pixels[i*PIXEL_W +: NUM_TAPS*PIXEL_W]),
            .pix   (out_pixels[i*PIXEL_W +: PIXEL_W])
`ifdef FIR_CLIP_FLAG_EN
            ,
            .sat   (out_clip[i])
`endif
        );
    end

endmodule

// File: tb/tb_hevc_luma_fir_pipe.sv
// Directed bench for hevc_luma_fir_pipe: latency, filter values, clipping, backpressure, row tags, reset.
module tb_hevc_luma_fir_pipe;

    localparam int NL    = 8;
    localparam int PW    = 8;
    localparam int BR    = 15;
    localparam int IN_W  = (NL + 7) * PW;
    localparam int OUT_W = NL * PW;

    localparam int TB_COEF [4][8] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{-1, 4, -10, 58, 17, -5, 1, 0},
        '{-1, 4, -11, 40, 40, -11, 4, -1},
        '{0, 1, -5, 17, 58, -10, 4, -1}
    };

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_frac;
    logic [IN_W-1:0]  in_pixels;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_pixels;
    logic             out_last;
`ifdef FIR_CLIP_FLAG_EN
    logic [NL-1:0]    out_clip;
`endif

    typedef struct {
        logic [OUT_W-1:0] pix;
        logic [NL-1:0]    clp;
        logic             last;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   row_m = 0;
    exp_t expq[$];
    int   lasts[$];

    always #5 clk = ~clk;

    hevc_luma_fir_pipe #(
        .NUM_LANES  (NL),
        .PIXEL_W    (PW),
        .BLOCK_ROWS (BR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_frac    (in_frac),
        .in_pixels  (in_pixels),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixels (out_pixels),
        .out_last   (out_last)
`ifdef FIR_CLIP_FLAG_EN
        ,
        .out_clip   (out_clip)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_beat(input logic [IN_W-1:0] px, input logic [1:0] fr,
                                     output logic [OUT_W-1:0] pix, output logic [NL-1:0] clp);
        pix = '0;
        clp = '0;
        for (int i = 0; i < NL; i++) begin
            if (fr == 2'd0) begin
                pix[i*PW +: PW] = px[(i+3)*PW +: PW];
            end else begin
                int s = 0;
                for (int k = 0; k < 8; k++) begin
                    s += TB_COEF[fr][k] * int'(px[(i+k)*PW +: PW]);
                end
                s = (s + 32) >>> 6;
                if (s < 0) begin
                    pix[i*PW +: PW] = 8'd0;
                    clp[i] = 1'b1;
                end else if (s > 255) begin
                    pix[i*PW +: PW] = 8'd255;
                    clp[i] = 1'b1;
                end else begin
                    pix[i*PW +: PW] = 8'(s);
                end
            end
        end
    endfunction

    task automatic push_beat;
        exp_t e;
        ref_beat(in_pixels, in_frac, e.pix, e.clp);
        e.last = (row_m == BR - 1);
        row_m  = (row_m + 1) % BR;
        expq.push_back(e);
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        e = expq[0];
        chk({tag, "_pix"}, out_pixels, e.pix);
        chk({tag, "_last"}, out_last, e.last);
`ifdef FIR_CLIP_FLAG_EN
        chk({tag, "_clip"}, out_clip, e.clp);
`endif
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        row_m = 0;
        expq.delete();
    endtask

    // Single beat into an idle pipe; returns with that beat on the output.
    task automatic send_direct(input logic [IN_W-1:0] px, input logic [1:0] fr, input string tag);
        in_pixels = px;
        in_frac   = fr;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        push_beat();
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_early"}, out_valid, 0);
        tick();
        chk({tag, "_out_valid"}, out_valid, 1);
        if (expq.size() > 0) begin
            check_head(tag);
            void'(expq.pop_front());
        end
    endtask

    task automatic run_stream(input int n, input bit rnd_ready, input string tag);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit stall_prev = 1'b0;
        bit fresh = 1'b1;
        lasts.delete();
        while ((sent < n || got < n) && cyc < 1000) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n) begin
                if (fresh) begin
                    for (int k = 0; k < NL + 7; k++) begin
                        in_pixels[k*PW +: PW] = 8'($urandom_range(0, 255));
                    end
                    in_frac = rnd_ready ? 2'($urandom_range(0, 3)) : 2'(sent % 4);
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_prev) chk({tag, "_held_valid"}, out_valid, 1);
            chk({tag, "_in_ready"}, in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk({tag, "_spurious"}, out_valid, 0);
                end else begin
                    check_head(tag);
                    if (out_ready) begin
                        if (out_last) lasts.push_back(got);
                        void'(expq.pop_front());
                        got++;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            fresh = in_valid && in_ready;
            if (fresh) begin
                push_beat();
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_beats_out"}, got, n);
    endtask

    initial begin
        logic [IN_W-1:0] px;

        in_frac   = 2'd0;
        in_pixels = '0;
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_pixels", out_pixels, 0);
        chk("rst_in_ready", in_ready, 1);

        // Flat field through the half-pel filter stays flat.
        for (int k = 0; k < NL + 7; k++) px[k*PW +: PW] = 8'd100;
        send_direct(px, 2'd2, "flatB");
        chk("flatB_hand", out_pixels, {8{8'd100}});

        // Single bright pixel under the 58 tap: 58*255 = 14790 -> 231.
        px = '0;
        px[3*PW +: PW] = 8'd255;
        send_direct(px, 2'd1, "impA");
        chk("impA_lane0", out_pixels[7:0], 231);
        px = '0;
        px[4*PW +: PW] = 8'd255;
        send_direct(px, 2'd3, "impC");
        chk("impC_lane0", out_pixels[7:0], 231);

        // 80*255 -> 319 saturates high; -16*255 -> -64 saturates low.
        px = '0;
        px[3*PW +: PW] = 8'd255;
        px[4*PW +: PW] = 8'd255;
        send_direct(px, 2'd2, "clipHi");
        chk("clipHi_lane0", out_pixels[7:0], 255);
`ifdef FIR_CLIP_FLAG_EN
        chk("clipHi_flag0", out_clip[0], 1);
`endif
        px = '0;
        for (int k = 0; k < 8; k++) px[k*PW +: PW] = (k == 3 || k == 4) ? 8'd0 : 8'd255;
        send_direct(px, 2'd2, "clipLo");
        chk("clipLo_lane0", out_pixels[7:0], 0);
`ifdef FIR_CLIP_FLAG_EN
        chk("clipLo_flag0", out_clip[0], 1);
`endif

        do_reset();
        run_stream(20, 1'b1, "bp");
        chk("bp_last_cnt", lasts.size(), 1);
        if (lasts.size() == 1) chk("bp_last_idx", lasts[0], 14);

        do_reset();
        run_stream(30, 1'b0, "rows");
        chk("rows_last_cnt", lasts.size(), 2);
        if (lasts.size() == 2) begin
            chk("rows_last_a", lasts[0], 14);
            chk("rows_last_b", lasts[1], 29);
        end

        // Two beats in flight when reset hits; neither may emerge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < NL + 7; k++) in_pixels[k*PW +: PW] = 8'd77;
        in_frac = 2'd2;
        tick();
        in_frac = 2'd1;
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        row_m = 0;
        expq.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_out_pixels", out_pixels, 0);
        tick();
        chk("midrst_flush1", out_valid, 0);
        tick();
        chk("midrst_flush2", out_valid, 0);
        run_stream(15, 1'b0, "post");
        chk("post_last_cnt", lasts.size(), 1);
        if (lasts.size() == 1) chk("post_last_idx", lasts[0], 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
